// File: rtl/message_arb_pkg.sv
// Shared types and constants for message_build_arbiter.
package message_arb_pkg;

  localparam int unsigned DATA_W   = 512;
  localparam int unsigned SIZE_W   = 64;
  localparam int unsigned SCHEME_W = 2;
  localparam int unsigned MAX_REQ  = 8;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;

  // Circular search for the first set bit of req, starting at ptr, over n
  // requesters. Returns ptr when nothing is requested; callers only use the
  // result when at least one bit is set.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if ((k < n) && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/message_arb_route_fifo.sv
// Route FIFO holding the owner ID of every message still inside the engine.
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module message_arb_route_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push,  do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  // Storage, pointers and count.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/message_build_arbiter.sv
// Whole-message arbiter sharing one message_build engine among NUM_REQ
// requesters; engine output is steered back through a route FIFO.
// Optional feature: MESSAGE_ARB_ROUND_ROBIN_EN selects rotating priority,
// otherwise fixed priority (lowest index wins).
module message_build_arbiter
  import message_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ROUTE_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [NUM_REQ*SIZE_W-1:0]     req_cfg_size,
  input  logic [NUM_REQ*SCHEME_W-1:0]   req_cfg_scheme,
  input  logic [NUM_REQ-1:0]            req_cfg_last,
  input  logic [NUM_REQ-1:0]            req_cfg_valid,
  output logic [NUM_REQ-1:0]            req_cfg_ready,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data_in,
  input  logic [NUM_REQ-1:0]            req_data_in_last,
  input  logic [NUM_REQ-1:0]            req_data_in_valid,
  output logic [NUM_REQ-1:0]            req_data_in_ready,
  output logic [NUM_REQ*DATA_W-1:0]     req_data_out,
  output logic [NUM_REQ-1:0]            req_data_out_last,
  output logic [NUM_REQ-1:0]            req_data_out_valid,
  input  logic [NUM_REQ-1:0]            req_data_out_ready,
  output logic [SIZE_W-1:0]             eng_cfg_size,
  output logic [SCHEME_W-1:0]           eng_cfg_scheme,
  output logic                          eng_cfg_last,
  output logic                          eng_cfg_valid,
  input  logic                          eng_cfg_ready,
  output logic [DATA_W-1:0]             eng_data_in,
  output logic                          eng_data_in_last,
  output logic                          eng_data_in_valid,
  input  logic                          eng_data_in_ready,
  input  logic [DATA_W-1:0]             eng_data_out,
  input  logic                          eng_data_out_last,
  input  logic                          eng_data_out_valid,
  output logic                          eng_data_out_ready
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(ROUTE_DEPTH) + 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             cfg_done_q, cfg_done_d;
  logic             data_done_q, data_done_d;
  logic             cfg_fin, data_fin;

  logic [MAX_REQ-1:0] req_pad;
  logic [2:0]         pick;
  logic [IDX_W-1:0]   winner;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_room;
  logic [IDX_W-1:0]   fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               out_ready;

`ifdef MESSAGE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
`endif

  // Grant decision uses the registered occupancy only.
  assign fifo_room = !fifo_full && (fifo_count < CNT_W'(ROUTE_DEPTH));

  // Winner selection among pending cfg requests.
  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req_cfg_valid;
`ifdef MESSAGE_ARB_ROUND_ROBIN_EN
    pick = rr_pick(req_pad, 3'(ptr_q), NUM_REQ);
`else
    pick = rr_pick(req_pad, 3'd0, NUM_REQ);
`endif
    winner = IDX_W'(pick);
  end

  // Next state, channel forwarding and completion flags.
  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    cfg_done_d        = cfg_done_q;
    data_done_d       = data_done_q;
    fifo_push         = 1'b0;
    cfg_fin           = 1'b0;
    data_fin          = 1'b0;
    eng_cfg_size      = '0;
    eng_cfg_scheme    = '0;
    eng_cfg_last      = 1'b0;
    eng_cfg_valid     = 1'b0;
    eng_data_in       = '0;
    eng_data_in_last  = 1'b0;
    eng_data_in_valid = 1'b0;
    req_cfg_ready     = '0;
    req_data_in_ready = '0;
`ifdef MESSAGE_ARB_ROUND_ROBIN_EN
    ptr_d             = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req_cfg_valid && fifo_room) begin
          state_d     = GRANT;
          owner_d     = winner;
          fifo_push   = 1'b1;
          cfg_done_d  = 1'b0;
          data_done_d = 1'b0;
`ifdef MESSAGE_ARB_ROUND_ROBIN_EN
          ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
`endif
        end
      end
      GRANT, DRAIN: begin
        if (!cfg_done_q) begin
          eng_cfg_size           = req_cfg_size[owner_q*SIZE_W +: SIZE_W];
          eng_cfg_scheme         = req_cfg_scheme[owner_q*SCHEME_W +: SCHEME_W];
          eng_cfg_last           = req_cfg_last[owner_q];
          eng_cfg_valid          = req_cfg_valid[owner_q];
          req_cfg_ready[owner_q] = eng_cfg_ready;
          cfg_fin = req_cfg_valid[owner_q] & eng_cfg_ready & req_cfg_last[owner_q];
        end
        if (!data_done_q) begin
          eng_data_in                = req_data_in[owner_q*DATA_W +: DATA_W];
          eng_data_in_last           = req_data_in_last[owner_q];
          eng_data_in_valid          = req_data_in_valid[owner_q];
          req_data_in_ready[owner_q] = eng_data_in_ready;
          data_fin = req_data_in_valid[owner_q] & eng_data_in_ready &
                     req_data_in_last[owner_q];
        end
        cfg_done_d  = cfg_done_q | cfg_fin;
        data_done_d = data_done_q | data_fin;
        if (cfg_done_d && data_done_d)      state_d = IDLE;
        else if (cfg_done_d || data_done_d) state_d = DRAIN;
        else                                state_d = GRANT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Return path: steer engine output to the owner at the route FIFO head.
  always_comb begin
    req_data_out       = '0;
    req_data_out_last  = '0;
    req_data_out_valid = '0;
    out_ready          = 1'b0;
    if (!fifo_empty) begin
      req_data_out[fifo_head*DATA_W +: DATA_W] = eng_data_out;
      req_data_out_last[fifo_head]             = eng_data_out_last;
      req_data_out_valid[fifo_head]            = eng_data_out_valid;
      out_ready                                = req_data_out_ready[fifo_head];
    end
    eng_data_out_ready = out_ready;
    fifo_pop           = eng_data_out_valid & out_ready & eng_data_out_last;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      cfg_done_q  <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cfg_done_q  <= cfg_done_d;
      data_done_q <= data_done_d;
    end
  end

`ifdef MESSAGE_ARB_ROUND_ROBIN_EN
  // Rotating priority pointer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  message_arb_route_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk         (clk),
    .nrst        (nrst),
    .push_i      (fifo_push),
    .push_data_i (owner_d),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

endmodule
